// File: rtl/column_render.sv
// rtl/column_render.sv - column buffer and 3-stage wall/ceiling/floor pixel classifier
// Optional write statistics enabled by defining COLUMN_RENDER_STATS_EN.
module column_render #(
  parameter int HALF_H   = 240,
  parameter int HEIGHT_K = 122880,
  parameter int COL_BASE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store,
  input  logic [9:0]  column,
  input  logic        side,
  input  logic [15:0] vdist,
  input  logic [5:0]  tex,
  input  logic [9:0]  h,
  input  logic [9:0]  v,
  input  logic        visible,
  output logic        px_valid,
  output logic        in_view,
  output logic        wall,
  output logic        floor,
  output logic        wall_side,
  output logic [5:0]  wall_tex
`ifdef COLUMN_RENDER_STATS_EN
  ,
  output logic [9:0]  stats_count,
  output logic        stats_full
`endif
);

  localparam logic [10:0] BASE   = 11'(COL_BASE);
  localparam logic [10:0] LAST   = 11'(COL_BASE + 511);
  localparam logic [9:0]  BASE10 = 10'(COL_BASE);
  localparam logic [9:0]  HH     = 10'(HALF_H);
  localparam logic [23:0] K      = 24'(HEIGHT_K);

  logic        wr_ok;
  logic [8:0]  wr_addr;
  logic [8:0]  rd_addr;
  logic        s0_in;
  logic [9:0]  dy_full;
  logic [7:0]  dy0;

  assign wr_ok   = store && ({1'b0, column} >= BASE) && ({1'b0, column} <= LAST);
  assign wr_addr = 9'(column - BASE10);
  assign rd_addr = 9'(h - BASE10);
  assign s0_in   = visible && ({1'b0, h} >= BASE) && ({1'b0, h} <= LAST);
  assign dy_full = (v < HH) ? (HH - v) : (v - HH);
  assign dy0     = (dy_full > 10'd255) ? 8'd255 : dy_full[7:0];

  // {side, vdist, tex}; contents survive reset
  logic [22:0] mem [512];
  logic [22:0] rd_data;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= {side, vdist, tex};
  end

  // Separate nonblocking read gives read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

  logic [7:0]  dy1;
  logic        in1, vis1, fl1;
  logic [23:0] prod2;
  logic        side2, in2, vis2, fl2;
  logic [5:0]  tex2;

  always_ff @(posedge clk) begin
    if (reset) begin
      dy1       <= '0;
      in1       <= 1'b0;
      vis1      <= 1'b0;
      fl1       <= 1'b0;
      prod2     <= '0;
      side2     <= 1'b0;
      tex2      <= '0;
      in2       <= 1'b0;
      vis2      <= 1'b0;
      fl2       <= 1'b0;
      px_valid  <= 1'b0;
      in_view   <= 1'b0;
      wall      <= 1'b0;
      floor     <= 1'b0;
      wall_side <= 1'b0;
      wall_tex  <= '0;
    end else begin
      dy1       <= dy0;
      in1       <= s0_in;
      vis1      <= visible;
      fl1       <= (v >= HH);

      prod2     <= {16'd0, dy1} * {8'd0, rd_data[21:6]};
      side2     <= rd_data[22];
      tex2      <= rd_data[5:0];
      in2       <= in1;
      vis2      <= vis1;
      fl2       <= fl1;

      px_valid  <= vis2;
      in_view   <= in2;
      wall      <= in2 && (prod2 < K);
      floor     <= fl2;
      wall_side <= in2 ? side2 : 1'b0;
      wall_tex  <= in2 ? tex2 : 6'd0;
    end
  end

`ifdef COLUMN_RENDER_STATS_EN
  logic [9:0] cnt;

  // Frame-start clear takes priority over a coincident write
  always_ff @(posedge clk) begin
    if (reset || (h == 10'd0 && v == 10'd0)) cnt <= '0;
    else if (wr_ok && cnt != 10'd512)        cnt <= cnt + 10'd1;
  end

  assign stats_count = cnt;
  assign stats_full  = (cnt == 10'd512);
`endif

endmodule

// File: doc/column_render.md
# column_render

Reader end of the tracer's column-result stream. Captures every `store` pulse from the tracer during VBLANK into a 512-entry column buffer. During active display it replays the buffer one pixel per clock. A 3-stage pipeline decides per pixel whether it is wall, ceiling or floor, and outputs wall side and texture column for the VGA colour logic.

## Interface
Parameters:
- `HALF_H`, default 240: screen row of the horizon; half-height of the view.
- `HEIGHT_K`, default 122880: wall threshold constant, equal to HALF_H × 512 (a wall at distance 1.0 fills the screen).
- `COL_BASE`, default 64: first traced screen column.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: synchronous, active-high.
- `store` input, 1 bit: write strobe from the tracer.
- `column` input, 10 bits: tracer column, valid range COL_BASE..COL_BASE+511.
- `side` input, 1 bit: hit side (0 = X gridline, 1 = Y gridline).
- `vdist` input, 16 bits: UQ7.9 perpendicular wall distance.
- `tex` input, 6 bits: texture column of the hit.
- `h` input, 10 bits: current VGA pixel column.
- `v` input, 10 bits: current VGA line.
- `visible` input, 1 bit: high in the active display region.
- `px_valid` output, 1 bit: outputs below correspond to an active pixel.
- `in_view` output, 1 bit: pixel lies in the traced 512-column window.
- `wall` output, 1 bit: pixel is wall.
- `floor` output, 1 bit: pixel row is at or below HALF_H (0 means ceiling half).
- `wall_side` output, 1 bit: stored side for this column.
- `wall_tex` output, 6 bits: stored texture column for this column.

## Operation
- **Storage:** 512 × 23-bit synchronous RAM holding {side, vdist, tex}. RAM contents are not reset.
- **Write:**
  - When `store`=1 and COL_BASE ≤ `column` ≤ COL_BASE+511, write to address `column`−COL_BASE.
  - Any other `column` value: the write is silently dropped.
  - Back-to-back stores on consecutive cycles are each written.
- **Stage 0** (inputs, combinational):
  - s0_in = `visible` & (COL_BASE ≤ `h` < COL_BASE+512).
  - Read address = `h`−COL_BASE, truncated to 9 bits.
  - dy = (`v` < HALF_H) ? HALF_H−`v` : `v`−HALF_H, 8 bits (saturate to 255).
- **Stage 1** (registered): RAM read data; registered dy, s0_in, `visible`, and floor = (`v` ≥ HALF_H).
- **Stage 2** (registered): prod = dy × vdist, 24-bit unsigned, full width with no truncation. side, tex, in_view, visible and floor are carried along.
- **Stage 3** (output registers):
  - `px_valid` = visible.
  - `in_view` = carried in_view.
  - `wall` = in_view & (prod < HEIGHT_K), unsigned 24-bit compare.
  - `wall_side` and `wall_tex` = stored values when in_view, else 0.
  - `floor` = carried floor.
- **Boundary cases:**
  - vdist = 0 → prod = 0 → full-height wall column.
  - vdist = 0xFFFF with dy = 0 → wall (horizon row is always wall inside the view).
  - Outside the view or when not visible → `wall`=0, `in_view`=0; `floor` still reflects `v`.
- **Write/read collision:** a write and a read to the same address in the same cycle returns the OLD data (read-before-write). No arbitration; the tracer only writes in VBLANK.
- **Valid bits:** there are no stalls. The pipeline advances every clock; valid bits shift with the data.

## Timing
- Latency: exactly 3 clocks from `h`/`v`/`visible` sampled at edge N to outputs valid after edge N+3. The top level delays hsync/vsync by 3 clocks to match.
- Throughput: 1 pixel per clock, continuous.
- Writes take effect at the clock edge where `store`=1. A read of that address issued on the following cycle returns the new data.
- Reset: all pipeline registers and all outputs go to 0 on the first clock edge with `reset`=1.
  - Outputs stay 0 while `reset` is held, and for 3 clocks after it is released (pipeline refill).
  - A reset asserted mid-line flushes all in-flight pixels; RAM is retained.

## Configuration
- Macro `COLUMN_RENDER_STATS_EN`.
- **Defined:** adds a 10-bit output `stats_count` and a 1-bit output `stats_full`.
  - `stats_count` counts accepted (in-range) writes and saturates at 512.
  - The count clears to 0 on the clock where `h`=0 and `v`=0, and on reset.
  - `stats_full` is 1 exactly when `stats_count`=512.
- **Undefined:** neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Write column 64 with vdist=512, side=1, tex=5; read h=64:
  - v=0 → after 3 clocks: wall=0 (240×512 = K, not less), floor=0, in_view=1.
  - v=1 → wall=1, wall_side=1, wall_tex=5.
  - v=479 → wall=1, floor=1.
- Write column 600 with vdist=0, then read h=575 (last valid column, previously written vdist=0) → wall=1 at all rows. Verify no RAM entry changed due to the column-600 write.
- Read h=10 and h=576 with visible=1 → px_valid=1, in_view=0, wall=0, wall_side=0, wall_tex=0.
- Write address 3 with vdist=100 while reading h=67 in the same cycle → returns the old entry. Reading h=67 the next cycle → returns vdist=100.
- Stream 10 pixels, assert reset for 1 clock mid-stream:
  - All outputs are 0 on the next cycle, and px_valid stays 0 for 3 clocks after release.
  - Stored data survives the reset.
- With `COLUMN_RENDER_STATS_EN`:
  - Issue 512 in-range stores plus 3 out-of-range stores → stats_count=512, stats_full=1.
  - Apply h=0, v=0 → stats_count=0.
